ifu_prefetch: RTL



---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fifo.sv | 63 ++++++
 rtl/ifu_prefetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and the {pc, instr} record used by the instruction-fetch unit.
package ifu_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_W_MAX = 64;

    localparam logic [PC_W_MAX-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    // pc is sized for the widest supported XLEN; narrower cores zero-extend into it.
    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Parametrised synchronous FIFO with flush and occupancy count; DEPTH must be a power of 2.
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        do_push  = push & ~flush;
        do_pop   = pop & (count_q != '0) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read after count marks it written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: credit-limited sequential fetch, in-order prefetch buffer and
// redirect handling that discards stale in-flight responses.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             active_q, active_d;

    logic             req_fire, keep_rsp, drop_rsp, out_pop;
    logic [SUM_W-1:0] credit_sum;
    logic [XLEN-1:0]  pcq_pc;
    logic [CNT_W-1:0] pcq_count, obuf_count;
    fetch_entry_t     obuf_wdata, obuf_rdata;
    logic             unused_bits;

    always_comb begin
        credit_sum = SUM_W'(live_q) + SUM_W'(drop_q) + SUM_W'(obuf_count);
        // active_q holds requests off until the first clock edge after reset release.
        imem_req_valid = active_q & ~redirect_valid & (credit_sum < SUM_W'(DEPTH));
        imem_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};
        req_fire       = imem_req_valid & imem_req_ready;
        keep_rsp       = imem_rsp_valid & (drop_q == '0);
        drop_rsp       = imem_rsp_valid & (drop_q != '0);

        out_valid = (obuf_count != '0);
        out_pop   = out_valid & out_ready;
        out_pc    = out_valid ? obuf_rdata.pc[XLEN-1:0] : '0;
        out_instr = out_valid ? obuf_rdata.instr : '0;

        obuf_wdata.pc    = PC_W_MAX'(pcq_pc);
        obuf_wdata.instr = imem_rsp_data;
    end

    always_comb begin
        active_d   = 1'b1;
        fetch_pc_d = fetch_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Every outstanding request becomes one to discard; a response arriving now is one fewer.
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            live_d     = '0;
            drop_d     = drop_q + live_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            live_d = live_q + CNT_W'(req_fire) - CNT_W'(keep_rsp);
            drop_d = drop_q - CNT_W'(drop_rsp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            fetch_pc_q <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
        end else begin
            active_q   <= active_d;
            fetch_pc_q <= fetch_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
        end
    end

    ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .wdata (imem_req_addr),
        .pop   (keep_rsp),
        .flush (redirect_valid),
        .rdata (pcq_pc),
        .count (pcq_count)
    );

    // The credit check guarantees a kept response always finds room here.
    ifu_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep_rsp & ~redirect_valid),
        .wdata (obuf_wdata),
        .pop   (out_pop),
        .flush (redirect_valid),
        .rdata (obuf_rdata),
        .count (obuf_count)
    );

    // PC-queue occupancy always equals live_q, and redirect_pc[1:0] is ignored by design.
    assign unused_bits = ^{pcq_count, redirect_pc[1:0]};

endmodule
